imem_arbiter: RTL and testbench

//   Shares the single instruction-memory port between the CPU fetch path and a debug/loader read port.

---
 rtl/imem_arbiter.sv | 77 +++++++
 tb/tb_imem_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one instruction-memory read port between CPU fetch and a debug/loader reader.
// Fetch wins by default; a starvation guard forces a debug grant after STARVE_LIM back-to-back fetches.
module imem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    output logic              cpu_stall,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_ce,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data
);
    localparam int CW = $clog2(MEM_LAT + 1);
    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;
    logic [0:0]        state;
    logic [CW-1:0]     cnt;
    logic [SW-1:0]     starve;
    logic              owner;
    logic [ADDR_W-1:0] addr;
    logic              idle, d_win, done;
    // grants are gated by rst so nothing is offered while reset is held
    assign idle      = rst & (state == S_IDLE);
    assign d_win     = d_req & ((starve == SW'(STARVE_LIM)) | ~f_req);
    assign d_gnt     = idle & d_win;
    assign f_gnt     = idle & f_req & ~d_win;
    assign cpu_stall = rst & f_req & ~f_gnt;
    assign mem_ce    = (state == S_WAIT);
    assign mem_addr  = mem_ce ? addr : '0;
    assign done      = mem_ce & (cnt == CW'(1));
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            starve   <= '0;
            owner    <= 1'b0;
            addr     <= '0;
            f_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            f_rdata  <= '0;
            d_rdata  <= '0;
        end else begin
            f_rvalid <= done & ~owner;
            d_rvalid <= done & owner;
            starve   <= (d_gnt | ~d_req) ? '0 : (f_gnt && starve != SW'(STARVE_LIM)) ? starve + 1'b1 : starve;
            if (f_gnt | d_gnt) begin
                state <= S_WAIT;
                owner <= d_gnt;
                addr  <= d_gnt ? d_addr : f_addr;
                cnt   <= CW'(MEM_LAT);
            end
            if (mem_ce)
                cnt <= cnt - 1'b1;
            if (done) begin
                state <= S_IDLE;
                if (owner)
                    d_rdata <= mem_data;
                else
                    f_rdata <= mem_data;
            end
        end
    end
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed and randomized traffic against a transaction-level model of the arbiter.
module tb_imem_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          f_req = 1'b0, d_req = 1'b0;
    logic [AW-1:0] f_addr = '0, d_addr = '0;
    logic [DW-1:0] junk = '0;
    logic          f_gnt, f_rvalid, cpu_stall, d_gnt, d_rvalid, mem_ce;
    logic [DW-1:0] f_rdata, d_rdata, mem_data;
    logic [AW-1:0] mem_addr;

    imem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_LIM(LIM)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .cpu_stall(cpu_stall),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_ce(mem_ce), .mem_addr(mem_addr), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
        return (a == 32'h4) ? 32'h3C010001 : ((a * 32'h9E3779B1) ^ 32'h0BADF00D);
    endfunction

    // memory returns garbage whenever it is not enabled, so mis-timed sampling shows up
    assign mem_data = mem_ce ? memval(mem_addr) : junk;

    typedef struct {
        int            due;
        logic          dbg;
        logic [AW-1:0] a;
    } acc_t;
    acc_t q[$];

    int            cyc = 0, n_cmp = 0, n_bad = 0, starve = 0, dg_first = -1, seg0 = 0;
    logic          g_f = 1'b0, g_d = 1'b0;
    logic [DW-1:0] f_last = '0, d_last = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_check();
        logic          efr = 1'b0, edr = 1'b0, ef = 1'b0, ed = 1'b0, busy;
        logic [AW-1:0] ea = '0;
        if (!rst) begin
            q.delete();
            f_last = '0;
            d_last = '0;
        end else if (q.size() != 0 && q[0].due == cyc) begin
            if (q[0].dbg) begin
                edr = 1'b1;
                d_last = memval(q[0].a);
            end else begin
                efr = 1'b1;
                f_last = memval(q[0].a);
            end
            void'(q.pop_front());
        end
        chk("f_rvalid", f_rvalid, efr);
        chk("d_rvalid", d_rvalid, edr);
        chk("f_rdata", f_rdata, f_last);
        chk("d_rdata", d_rdata, d_last);
        busy = (q.size() != 0);
        if (busy) ea = q[0].a;
        chk("mem_ce", mem_ce, busy);
        chk("mem_addr", mem_addr, ea);
        if (rst && !busy) begin
            ed = d_req && (starve >= LIM || !f_req);
            ef = f_req && !ed;
        end
        chk("f_gnt", f_gnt, ef);
        chk("d_gnt", d_gnt, ed);
        chk("cpu_stall", cpu_stall, rst && f_req && !ef);
        if (ef || ed) q.push_back('{cyc + LAT + 1, ed, ed ? d_addr : f_addr});
        if (d_gnt && dg_first < 0) dg_first = cyc;
        starve = (!rst || ed || !d_req) ? 0 : (ef && starve < LIM) ? starve + 1 : starve;
        g_f = ef;
        g_d = ed;
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1 junk = $urandom;
    endtask

    task automatic serve(input int budget);
        int b = budget;
        while ((f_req || d_req) && b > 0) begin
            tick();
            if (g_f) f_req = 1'b0;
            if (g_d) d_req = 1'b0;
            b--;
        end
        chk("serve_done", {f_req, d_req}, 2'b00);
        f_req = 1'b0;
        d_req = 1'b0;
        repeat (LAT + 2) tick();
    endtask

    initial begin
        int k;
        f_req = 1'b1; d_req = 1'b1; f_addr = 32'h8; d_addr = 32'hC;
        repeat (3) tick();
        rst = 1'b1;
        serve(20);

        f_req = 1'b1; f_addr = 32'h4;
        serve(10);

        k = 0; f_req = 1'b1; f_addr = 32'h0;
        for (int i = 0; i < 30 && f_req; i++) begin
            tick();
            if (g_f) begin
                k++;
                f_addr = 32'(4 * k);
                if (k == 3) f_req = 1'b0;
            end
        end
        serve(1);

        f_req = 1'b1; d_req = 1'b1; f_addr = 32'h100; d_addr = 32'h200;
        seg0 = cyc; dg_first = -1;
        repeat (16) begin
            tick();
            if (g_f) f_addr = f_addr + 32'h4;
            if (g_d) d_req = 1'b0;
        end
        chk("starve_dgnt_cycle", 64'(dg_first - seg0), 64'd12);
        serve(10);

        f_req = 1'b1; f_addr = 32'h40;
        tick();
        f_req = 1'b0; d_req = 1'b1; d_addr = 32'h44; rst = 1'b0;
        tick();
        rst = 1'b1;
        serve(10);

        f_req = 1'b1; f_addr = 32'h80;
        tick();
        f_req = 1'b0; d_req = 1'b1; d_addr = 32'h84;
        tick();
        d_req = 1'b0;
        repeat (5) tick();

        for (int i = 0; i < 3000; i++) begin
            tick();
            rst = ($urandom_range(0, 299) != 0);
            if (g_f || !f_req) begin
                f_req = ($urandom_range(0, 2) != 0);
                f_addr = $urandom;
            end else if ($urandom_range(0, 15) == 0) f_req = 1'b0;
            if (g_d || !d_req) begin
                d_req = ($urandom_range(0, 3) == 0);
                d_addr = $urandom;
            end else if ($urandom_range(0, 15) == 0) d_req = 1'b0;
        end
        rst = 1'b1;
        serve(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
